// File: rtl/lcd_timing.sv
// lcd_timing: pixel-clock divider plus horizontal/vertical raster counters for
// a parallel RGB panel. Produces the panel syncs and pixel clock together with
// per-pixel and per-frame strobes for the frame-buffer streaming stage.
// All outputs are decoded from registers only, so an asynchronous reset
// clears them immediately and enable never reaches an output combinationally.
module lcd_timing #(
    parameter int CLOCK_DIVIDER = 4,
    parameter int H_ACTIVE      = 800,
    parameter int H_FRONT       = 40,
    parameter int H_SYNC        = 48,
    parameter int H_BACK        = 88,
    parameter int V_ACTIVE      = 480,
    parameter int V_FRONT       = 13,
    parameter int V_SYNC        = 3,
    parameter int V_BACK        = 32,
    parameter int SYNC_POLARITY = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    output logic        lcd_pclk,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic        lcd_data_enable,
    output logic        lcd_tick,
    output logic        lcd_next_frame,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLOCK_DIVIDER);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDER - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLOCK_DIVIDER / 2);

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    // Level driven onto a sync pin while it is asserted.
    localparam logic SYNC_ON = (SYNC_POLARITY != 0);

    logic             running_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [10:0]      h_q, h_d;
    logic [10:0]      v_q, v_d;
    logic [15:0]      frame_count_q, frame_count_d;

    logic div_wrap, h_wrap, v_wrap;

    assign div_wrap = (div_q == DIV_LAST);
    assign h_wrap   = (h_q == H_LAST);
    assign v_wrap   = (v_q == V_LAST);

    // Raster advance; counters collapse to 0 whenever timing is not (or will
    // not be) running, so x/y read 0 while idle and a re-enable starts clean.
    always_comb begin
        div_d = '0;
        h_d   = '0;
        v_d   = '0;
        if (running_q && enable) begin
            div_d = div_wrap ? '0 : div_q + 1'b1;
            h_d   = h_q;
            v_d   = v_q;
            if (div_wrap) begin
                h_d = h_wrap ? '0 : h_q + 11'd1;
                if (h_wrap) begin
                    v_d = v_wrap ? '0 : v_q + 11'd1;
                end
            end
        end
        frame_count_d = frame_count_q + {15'd0, lcd_next_frame};
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            running_q     <= 1'b0;
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            frame_count_q <= '0;
        end else begin
            running_q     <= enable;
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign lcd_tick        = running_q && div_wrap;
    assign lcd_pclk        = running_q && (div_q >= DIV_HALF);
    assign lcd_data_enable = running_q && (h_q < H_ACT) && (v_q < V_ACT);
    assign lcd_hsync       = (running_q && h_q >= HS_START && h_q < HS_END) ? SYNC_ON : !SYNC_ON;
    assign lcd_vsync       = (running_q && v_q >= VS_START && v_q < VS_END) ? SYNC_ON : !SYNC_ON;
    // Fires as vertical front porch begins, leaving all of blanking for refill.
    assign lcd_next_frame  = lcd_tick && h_wrap && (v_q == V_ACT_LAST);
    assign x               = h_q;
    assign y               = v_q;
    assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_lcd_timing.sv
// Bench for lcd_timing with a small raster (7x6 pixels, 2 clocks per pixel).
// The reference derives every output from the number of clocks elapsed since
// timing started, using plain division/modulo on the raster geometry.
module tb_lcd_timing;

    localparam int D  = 2;
    localparam int HA = 4, HF = 1, HS = 1, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = D * HT * VT;

    // {pclk, hsync, vsync, de, tick, next_frame, x, y, frame_count}
    localparam logic [43:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 3'b000, 11'd0, 11'd0, 16'd0};

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        lcd_pclk, lcd_hsync, lcd_vsync, lcd_data_enable, lcd_tick, lcd_next_frame;
    logic [10:0] x, y;
    logic [15:0] frame_count;
    logic [43:0] obs;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference state: running flag, clocks since start, completed frames.
    bit          m_run = 1'b0;
    int          m_t   = 0;
    logic [15:0] m_fc  = 16'd0;

    lcd_timing #(
        .CLOCK_DIVIDER(D),
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POLARITY(0)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .lcd_pclk(lcd_pclk),
        .lcd_hsync(lcd_hsync),
        .lcd_vsync(lcd_vsync),
        .lcd_data_enable(lcd_data_enable),
        .lcd_tick(lcd_tick),
        .lcd_next_frame(lcd_next_frame),
        .x(x),
        .y(y),
        .frame_count(frame_count)
    );

    assign obs = {lcd_pclk, lcd_hsync, lcd_vsync, lcd_data_enable, lcd_tick,
                  lcd_next_frame, x, y, frame_count};

    always #5 clock = ~clock;

    function automatic logic [43:0] model_out();
        int   dv, h, v;
        logic pclk, hs, vs, de, tick, nf;
        dv   = m_t % D;
        h    = (m_t / D) % HT;
        v    = (m_t / (D * HT)) % VT;
        pclk = m_run && dv >= D / 2;
        tick = m_run && dv == D - 1;
        de   = m_run && h < HA && v < VA;
        hs   = (m_run && h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
        vs   = (m_run && v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
        nf   = tick && h == HT - 1 && v == VA - 1;
        if (!m_run) begin
            h = 0;
            v = 0;
        end
        return {pclk, hs, vs, de, tick, nf, 11'(h), 11'(v), m_fc};
    endfunction

    function automatic int model_v();
        return m_run ? (m_t / (D * HT)) % VT : 0;
    endfunction

    // Drive enable for one clock and advance the reference; returns at negedge.
    task automatic step(input bit en);
        logic [43:0] e;
        e = model_out();
        enable = en;
        @(posedge clock);
        if (e[38]) m_fc = m_fc + 16'd1;
        if (en) begin
            if (m_run) m_t++;
            else m_t = 0;
            m_run = 1'b1;
        end else begin
            m_run = 1'b0;
            m_t   = 0;
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic test_reset();
        logic [43:0] e;
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if (obs !== RESET_VEC) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=%h", obs, RESET_VEC);
        end
        reset_n = 1'b1;
        m_run = 1'b0; m_t = 0; m_fc = 16'd0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            e = model_out();
            total++;
            if (obs !== e || obs !== RESET_VEC) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, RESET_VEC);
            end
        end
    endtask

    task automatic test_line_timing();
        logic [43:0] e;
        int de_cnt = 0, tick_cnt = 0;
        for (int i = 0; i < 3 * D * HT; i++) begin
            step(1'b1);
            e = model_out();
            if (i < D * HT) begin
                de_cnt   += int'(lcd_data_enable);
                tick_cnt += int'(lcd_tick);
            end
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL line_timing cyc=%0d got=%h exp=%h", cyc, obs, e);
            end
        end
        total++;
        if (de_cnt !== D * HA || tick_cnt !== HT) begin
            bad++;
            $display("FAIL line_counts de=%0d tick=%0d exp de=%0d tick=%0d", de_cnt, tick_cnt, D * HA, HT);
        end
    endtask

    task automatic test_frames();
        logic [43:0] e;
        logic [15:0] fc0;
        int pulses = 0, last = -1;
        step(1'b0);
        step(1'b0);
        fc0 = m_fc;
        for (int i = 0; i < 3 * FRAME + 2; i++) begin
            step(1'b1);
            e = model_out();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL frames cyc=%0d got=%h exp=%h", cyc, obs, e);
            end
            if (lcd_next_frame === 1'b1) begin
                pulses++;
                total++;
                if (x !== 11'd6 || y !== 11'd2 || lcd_tick !== 1'b1 || (last >= 0 && cyc - last != FRAME)) begin
                    bad++;
                    $display("FAIL frame_pulse cyc=%0d x=%0d y=%0d tick=%b gap=%0d exp x=6 y=2 tick=1 gap=%0d",
                             cyc, x, y, lcd_tick, cyc - last, FRAME);
                end
                last = cyc;
            end
        end
        total++;
        if (pulses != 3 || frame_count !== fc0 + 16'd3) begin
            bad++;
            $display("FAIL frame_total pulses=%0d fc=%0d exp pulses=3 fc=%0d", pulses, frame_count, fc0 + 16'd3);
        end
    endtask

    task automatic test_disable();
        logic [43:0] e;
        int guard = 0;
        int extra;
        step(1'b0);
        step(1'b1);
        while (model_v() != 1 && guard < 200) begin
            step(1'b1);
            guard++;
        end
        total++;
        if (guard >= 200) begin
            bad++;
            $display("FAIL disable_reach_v1 got=timeout exp=v1");
        end
        extra = $urandom_range(0, D * HT - 1);
        for (int i = 0; i < extra; i++) step(1'b1);
        step(1'b0);
        e = model_out();
        total++;
        if (obs !== e || obs[43:16] !== RESET_VEC[43:16]) begin
            bad++;
            $display("FAIL disable_idle cyc=%0d got=%h exp=%h", cyc, obs, e);
        end
        step(1'b1);
        e = model_out();
        total++;
        if (obs !== e || x !== 11'd0 || y !== 11'd0 || lcd_data_enable !== 1'b1) begin
            bad++;
            $display("FAIL disable_restart cyc=%0d got=%h exp=%h", cyc, obs, e);
        end
    endtask

    task automatic test_random();
        logic [43:0] e;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 97);
            e = model_out();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL random cyc=%0d en=%b got=%h exp=%h", cyc, enable, obs, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [43:0] e;
        step(1'b0);
        step(1'b0);
        // Skip ~65534 frames by loading the frame counter directly.
        force dut.frame_count_q = 16'hFFFE;
        @(negedge clock);
        release dut.frame_count_q;
        m_fc = 16'hFFFE;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            step(1'b1);
            e = model_out();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs, e);
            end
        end
        total++;
        if (frame_count !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_zero got=%h exp=0000", frame_count);
        end
    endtask

    task automatic test_async_reset();
        logic [43:0] e;
        int guard = 0;
        int pre;
        step(1'b0);
        pre = $urandom_range(1, 60);
        for (int i = 0; i < pre; i++) step(1'b1);
        e = model_out();
        while (e[40] !== 1'b1 && guard < 100) begin
            step(1'b1);
            e = model_out();
            guard++;
        end
        total++;
        if (lcd_data_enable !== 1'b1) begin
            bad++;
            $display("FAIL async_setup de=%b exp=1", lcd_data_enable);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (obs !== RESET_VEC) begin
            bad++;
            $display("FAIL async_clear got=%h exp=%h", obs, RESET_VEC);
        end
        m_run = 1'b0; m_t = 0; m_fc = 16'd0;
        enable = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b0);
        e = model_out();
        total++;
        if (obs !== e || obs !== RESET_VEC) begin
            bad++;
            $display("FAIL async_idle got=%h exp=%h", obs, RESET_VEC);
        end
        step(1'b1);
        e = model_out();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL async_restart got=%h exp=%h", obs, e);
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frames();
        test_disable();
        test_random();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
